c2c_host_ctrl: RTL
==================

# c2c_host_ctrl

Command sequencer sitting directly upstream of `c2cmodule`. It owns the `cmd`/`datain`/`datavalid`/`PID` drive and the `busy`/`wd`/`outvalid`/`pagefault` polling protocol. It turns an upstream init byte stream plus a translate request/response handshake into the write-cache → load-c2c → translate command sequence. Software-side logic no longer polls `c2cmodule` directly.

## Interface
Parameters:
- `INIT_BYTES`, 21: bytes written to cache per init sequence.
- `TO_CYCLES`, 255: watchdog limit, in cycles, for any single busy/idle wait. Only used with the timeout feature.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset. All state clears immediately on assertion.
- `start`, in, 1: one-cycle pulse that begins an init sequence.
- `init_data`, in, 8: cache byte stream.
- `init_valid`, in, 1: valid for `init_data`.
- `init_ready`, out, 1: a byte is accepted when `init_valid & init_ready`.
- `init_pid`, in, 4: PID driven during writes; sampled on `start`.
- `req_valid`, in, 1: translate request valid.
- `req_ready`, out, 1: translate request ready.
- `req_pid`, in, 4: requesting PID.
- `req_vaddr`, in, 8: virtual address byte.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_data`, out, 8: translated data.
- `rsp_fault`, out, 1: page fault flag.
- `rsp_timeout`, out, 1: watchdog expiry flag.
- `cmd`, out, 2: to `c2cmodule`.
- `datain`, out, 8: to `c2cmodule`.
- `datavalid`, out, 1: to `c2cmodule`.
- `PID`, out, 4: to `c2cmodule`.
- `busy`, in, 1: from `c2cmodule`.
- `wd`, in, 1: from `c2cmodule`.
- `outvalid`, in, 1: from `c2cmodule`.
- `pagefault`, in, 1: from `c2cmodule`.
- `ready`, out, 1: high while init is complete and the block is able to accept translates.
- `err`, out, 1: sticky error flag.

## Operation
- Command encoding: NOP=00, WRITE=01, LOAD=10, XLATE=11.
- All downstream outputs are registered.

State machine:
- **IDLE**: `cmd`=NOP. `start` → WRITE; captures `init_pid` into `PID` and clears the byte counter.
- **WRITE**: `cmd`=WRITE.
  - `init_ready = wd & busy`.
  - On each accepted byte, the next cycle drives `datain`=byte and `datavalid`=1 for exactly one cycle, and the counter increments.
  - Otherwise `datavalid`=0 (polling).
  - When the counter reaches `INIT_BYTES` → DRAIN.
- **DRAIN**: `cmd`=NOP for one cycle → LWAIT.
- **LWAIT**: `cmd`=NOP until `wd & ~busy` → LISSUE.
- **LISSUE**: `cmd`=LOAD, held until `busy`=1 → LBUSY.
- **LBUSY**: wait for `busy`=0. Then `cmd`=NOP, `ready`=1 → RDY.
- **RDY**:
  - `req_ready = ~busy & ~start`.
  - An accepted request registers `PID`=`req_pid`, `datain`=`req_vaddr`, `cmd`=XLATE → XBUSY.
  - `start` → WRITE (re-init; `ready` drops).
- **XBUSY**: `cmd` held XLATE until `busy`=1. Then `cmd`=NOP → XWAIT.
- **XWAIT**: capture `dataout` and `pagefault` on any cycle with `outvalid`=1. When `busy`=0 → RSP.
- **RSP**:
  - `rsp_valid`=1 for one cycle.
  - `rsp_data` = captured value, or 0 if no `outvalid` was seen.
  - `rsp_fault` = captured `pagefault`.
  - → RDY.
- **ERR**: `err`=1, `cmd`=NOP. Only `start` (→ WRITE, clears `err`) or reset exits.

Boundary rules:
- `start` outside IDLE/RDY/ERR is ignored.
- `start` and `req_valid` in the same RDY cycle: `start` wins.
- `rsp_*` fields hold their values until the next response.
- Byte counter is 8 bits wide.
- `INIT_BYTES` ≥ 1.

## Timing
- Reset values:
  - `cmd`=00, `datain`=0, `datavalid`=0, `PID`=0.
  - `init_ready`=0, `req_ready`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_fault`=0, `rsp_timeout`=0.
  - `ready`=0, `err`=0, state IDLE.
- Reset mid-sequence forces `cmd`=NOP asynchronously. Any partial cache write is abandoned.
- Byte acceptance to `datavalid` pulse: 1 cycle.
- Request acceptance to `cmd`=XLATE visible: 1 cycle.
- `busy` falling in XWAIT to `rsp_valid`: 1 cycle.
- `init_ready` is combinational from `wd`/`busy` and the state. `req_ready` is combinational from the state, `busy` and `start`.

## Configuration
- `C2C_CTRL_TIMEOUT_EN` defined:
  - Every wait state (WRITE byte wait, LWAIT, LISSUE, LBUSY, XBUSY, XWAIT) has a counter that resets on state entry.
  - Reaching `TO_CYCLES` → ERR.
  - If this happens in XBUSY/XWAIT, an RSP pulse with `rsp_timeout`=1 and `rsp_data`=0 is emitted first.
- Undefined: waits are unbounded, `rsp_timeout` is tied to 0, and ERR is unreachable.

## Structure
- Shared package `c2c_pkg` holds:
  - the command encodings `C2C_CMD_NOP`, `C2C_CMD_WRITE`, `C2C_CMD_LOAD`, `C2C_CMD_XLATE`;
  - the FSM state enum.
- One sub-module, `c2c_watchdog`: a loadable down-counter with `clear`/`expire`. It is instantiated only under `C2C_CTRL_TIMEOUT_EN`.

## Test plan
- **Init sequence**: `start` with 21 bytes 0x00..0x14 and `init_pid`=4; model asserts `wd`=`busy`=1.
  - Expect 21 single-cycle `datavalid` pulses carrying 0x00..0x14 in order, `PID`=4, then one NOP cycle.
- **Load**: `wd`=1, `busy`=0 → `cmd`=10 until `busy`=1; `busy` falls → `ready`=1 on the next cycle.
- **Translate**: `req_pid`=8, `req_vaddr`=0x18; model returns `dataout`=0x5A with `outvalid`.
  - Expect `cmd`=11, `datain`=0x18, `PID`=8, then `rsp_valid` pulse with `rsp_data`=0x5A, `rsp_fault`=0.
- **Fault**: same request; model returns `pagefault`=1 and no `outvalid` → `rsp_data`=0x00, `rsp_fault`=1.
- **Reset mid-WRITE**: drop `rst` after byte 10 → `cmd`=00 immediately, state IDLE. A following `start` writes all 21 bytes again.
- **Timeout (macro on, `TO_CYCLES`=16)**: hold `busy`=1 forever after XLATE → `rsp_valid` with `rsp_timeout`=1, then `err`=1. `start` clears `err`.

Source files
------------

// File: rtl/c2c_pkg.sv
// c2c_pkg: definitions shared by the c2c host controller and its watchdog.
//   - C2C_CMD_*     : 2-bit command encodings driven onto c2cmodule.cmd
//   - c2c_state_e   : controller FSM state (also exported on dbg_state)
//   - cmd_for_state : command a given state drives downstream
//   - is_wait_state : states that block on c2cmodule and are watchdog-bounded
package c2c_pkg;

   localparam logic [1:0] C2C_CMD_NOP   = 2'b00;
   localparam logic [1:0] C2C_CMD_WRITE = 2'b01;
   localparam logic [1:0] C2C_CMD_LOAD  = 2'b10;
   localparam logic [1:0] C2C_CMD_XLATE = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_WRITE  = 4'd1,
      ST_DRAIN  = 4'd2,
      ST_LWAIT  = 4'd3,
      ST_LISSUE = 4'd4,
      ST_LBUSY  = 4'd5,
      ST_RDY    = 4'd6,
      ST_XBUSY  = 4'd7,
      ST_XWAIT  = 4'd8,
      ST_RSP    = 4'd9,
      ST_ERR    = 4'd10
   } c2c_state_e;

   function automatic logic [1:0] cmd_for_state(input c2c_state_e s);
      case (s)
         ST_WRITE:  return C2C_CMD_WRITE;
         ST_LISSUE: return C2C_CMD_LOAD;
         ST_XBUSY:  return C2C_CMD_XLATE;
         default:   return C2C_CMD_NOP;
      endcase
   endfunction

   function automatic logic is_wait_state(input c2c_state_e s);
      return (s == ST_WRITE) || (s == ST_LWAIT) || (s == ST_LISSUE) ||
             (s == ST_LBUSY) || (s == ST_XBUSY) || (s == ST_XWAIT);
   endfunction

endpackage

// File: rtl/c2c_watchdog.sv
// c2c_watchdog: loadable down-counter bounding a single wait.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset (counter reloads)
//   clear  : reload the counter to LIMIT-1 (state entry / progress)
//   expire : high once LIMIT cycles have elapsed since the last clear
module c2c_watchdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic expire
);
   localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [W-1:0] LOAD_VAL = W'(LIMIT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= LOAD_VAL;
      end else if (clear) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/c2c_host_ctrl.sv
// c2c_host_ctrl: command sequencer in front of c2cmodule. Streams INIT_BYTES
// cache bytes (WRITE), issues LOAD, then serves translate requests (XLATE)
// and returns one response pulse per request.
// Optional feature: define C2C_CTRL_TIMEOUT_EN to bound every wait with a
// TO_CYCLES watchdog (expiry -> ERR, with a timeout response if mid-translate).
// Ports:
//   clk, rst (async active-low)        start, init_pid
//   init_data/init_valid/init_ready     byte stream, accepted on valid & ready
//   req_valid/req_ready/req_pid/req_vaddr  translate request, accepted on valid & ready
//   rsp_valid/rsp_data/rsp_fault/rsp_timeout  response (fields hold between pulses)
//   cmd/datain/datavalid/PID            registered drive to c2cmodule
//   busy/wd/outvalid/pagefault/dataout  status from c2cmodule
//   ready, err                          status; dbg_state exposes the FSM state
// Handshake: a transfer happens in the cycle where valid and ready are both
// high at the rising edge; ready never depends on valid.
module c2c_host_ctrl
   import c2c_pkg::*;
#(
   parameter int unsigned INIT_BYTES = 21,
   parameter int unsigned TO_CYCLES  = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] init_data,
   input  logic       init_valid,
   output logic       init_ready,
   input  logic [3:0] init_pid,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_pid,
   input  logic [7:0] req_vaddr,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_fault,
   output logic       rsp_timeout,
   output logic [1:0] cmd,
   output logic [7:0] datain,
   output logic       datavalid,
   output logic [3:0] PID,
   input  logic       busy,
   input  logic       wd,
   input  logic       outvalid,
   input  logic       pagefault,
   input  logic [7:0] dataout,
   output logic       ready,
   output logic       err,
   output c2c_state_e dbg_state
);
   localparam logic [7:0] INIT_CNT = 8'(INIT_BYTES);

   c2c_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] datain_d;
   logic       datavalid_d;
   logic [3:0] pid_d;
   logic [7:0] cap_data_q, cap_data_d;
   logic       cap_fault_q, cap_fault_d;
   logic       to_pend_q, to_pend_d;
   logic [7:0] rsp_data_d;
   logic       rsp_fault_d, rsp_timeout_d;
   logic       byte_acc, req_acc, tmo_expire;

   // Last byte's datavalid pulse is still in flight when cnt hits INIT_CNT,
   // so stop accepting there rather than one cycle later.
   assign init_ready = (state_q == ST_WRITE) & wd & busy & (cnt_q != INIT_CNT);
   assign req_ready  = (state_q == ST_RDY) & ~busy & ~start;
   assign byte_acc   = init_valid & init_ready;
   assign req_acc    = req_valid & req_ready;
   assign dbg_state  = state_q;

`ifdef C2C_CTRL_TIMEOUT_EN
   logic tmo_clear, tmo_hit;
   // Restart the wait on every state change and on every accepted byte.
   assign tmo_clear = (state_d != state_q) | byte_acc;
   c2c_watchdog #(.LIMIT(TO_CYCLES)) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmo_clear),
      .expire (tmo_hit)
   );
   assign tmo_expire = tmo_hit & is_wait_state(state_q);
`else
   // Without the watchdog TO_CYCLES has no effect.
   logic unused_to;
   assign unused_to  = (TO_CYCLES != 0);
   assign tmo_expire = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      datain_d      = datain;
      datavalid_d   = 1'b0;
      pid_d         = PID;
      cap_data_d    = cap_data_q;
      cap_fault_d   = cap_fault_q;
      to_pend_d     = to_pend_q;
      rsp_data_d    = rsp_data;
      rsp_fault_d   = rsp_fault;
      rsp_timeout_d = rsp_timeout;
      unique case (state_q)
         ST_IDLE, ST_ERR: begin
            if (start) begin
               state_d = ST_WRITE;
               pid_d   = init_pid;
               cnt_d   = 8'd0;
            end
         end
         ST_WRITE: begin
            if (cnt_q == INIT_CNT) begin
               state_d = ST_DRAIN;
            end else if (byte_acc) begin
               datain_d    = init_data;
               datavalid_d = 1'b1;
               cnt_d       = cnt_q + 8'd1;
            end else if (tmo_expire) begin
               state_d = ST_ERR;
            end
         end
         ST_DRAIN: state_d = ST_LWAIT;
         ST_LWAIT: begin
            if (wd & ~busy)      state_d = ST_LISSUE;
            else if (tmo_expire) state_d = ST_ERR;
         end
         ST_LISSUE: begin
            if (busy)            state_d = ST_LBUSY;
            else if (tmo_expire) state_d = ST_ERR;
         end
         ST_LBUSY: begin
            if (~busy)           state_d = ST_RDY;
            else if (tmo_expire) state_d = ST_ERR;
         end
         ST_RDY: begin
            if (start) begin
               state_d = ST_WRITE;
               pid_d   = init_pid;
               cnt_d   = 8'd0;
            end else if (req_acc) begin
               state_d     = ST_XBUSY;
               pid_d       = req_pid;
               datain_d    = req_vaddr;
               cap_data_d  = 8'd0;
               cap_fault_d = 1'b0;
            end
         end
         ST_XBUSY: begin
            if (busy) begin
               state_d = ST_XWAIT;
            end else if (tmo_expire) begin
               state_d       = ST_RSP;
               to_pend_d     = 1'b1;
               rsp_data_d    = 8'd0;
               rsp_fault_d   = 1'b0;
               rsp_timeout_d = 1'b1;
            end
         end
         ST_XWAIT: begin
            if (outvalid) cap_data_d = dataout;
            // A fault may be flagged without outvalid, so it is sticky for
            // the whole wait.
            cap_fault_d = cap_fault_q | pagefault;
            if (~busy) begin
               state_d       = ST_RSP;
               rsp_data_d    = cap_data_d;
               rsp_fault_d   = cap_fault_d;
               rsp_timeout_d = 1'b0;
            end else if (tmo_expire) begin
               state_d       = ST_RSP;
               to_pend_d     = 1'b1;
               rsp_data_d    = 8'd0;
               rsp_fault_d   = 1'b0;
               rsp_timeout_d = 1'b1;
            end
         end
         ST_RSP: begin
            state_d   = to_pend_q ? ST_ERR : ST_RDY;
            to_pend_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         cmd         <= C2C_CMD_NOP;
         datain      <= 8'd0;
         datavalid   <= 1'b0;
         PID         <= 4'd0;
         cap_data_q  <= 8'd0;
         cap_fault_q <= 1'b0;
         to_pend_q   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= 8'd0;
         rsp_fault   <= 1'b0;
         rsp_timeout <= 1'b0;
         ready       <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd         <= cmd_for_state(state_d);
         datain      <= datain_d;
         datavalid   <= datavalid_d;
         PID         <= pid_d;
         cap_data_q  <= cap_data_d;
         cap_fault_q <= cap_fault_d;
         to_pend_q   <= to_pend_d;
         rsp_valid   <= (state_d == ST_RSP);
         rsp_data    <= rsp_data_d;
         rsp_fault   <= rsp_fault_d;
         rsp_timeout <= rsp_timeout_d;
         ready       <= (state_d == ST_RDY);
         err         <= (state_d == ST_ERR);
      end
   end

endmodule
